// File: rtl/msg_queue_pkg.sv
// Shared field positions, command codes and sizing helpers for the
// multi-channel packet-to-message queue.
package msg_queue_pkg;

  localparam int FLIT_TYPE_BITS     = 2;
  localparam int CMD_BITS_HEAD_FLIT = 2;

  localparam logic [FLIT_TYPE_BITS-1:0]     HEAD_TAIL_FLIT = 2'b11;
  localparam logic [CMD_BITS_HEAD_FLIT-1:0] CMD_READ       = 2'b01;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

  function automatic int popcount_sel(input logic [63:0] sel);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++)
      if (sel[i]) n = n + 1;
    return n;
  endfunction

  function automatic int burst_from_flits(input int nf, input int flit_w, input int bus_w);
    return (nf * flit_w + bus_w - 1) / bus_w;
  endfunction

endpackage

// File: rtl/msg_queue_mc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from unmasked requests, searching from a
// priority pointer that moves past each granted channel.
module rr_arbiter
  import msg_queue_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (clog2(N) < 1) ? 1 : clog2(N);

  logic [PW-1:0] prio;
  logic [PW-1:0] prio_next;
  logic [PW-1:0] idx_b;
  logic          found;
  int            idx;

  always_comb begin
    gnt       = '0;
    prio_next = prio;
    found     = 1'b0;
    idx       = 0;
    idx_b     = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(prio) + i;
      if (idx >= N) idx = idx - N;
      idx_b = PW'(idx);
      if (en && !found && req[idx_b] && !mask[idx_b]) begin
        found      = 1'b1;
        gnt[idx_b] = 1'b1;
        prio_next  = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       prio <= '0;
    else if (|gnt) prio <= prio_next;
  end

endmodule

// File: rtl/msg_queue_mc.sv
// Multi-channel packet-to-message queue: stores whole packets granted from
// N_CH flit buffers and presents the head message as WISHBONE beats.
module msg_queue_mc
  import msg_queue_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DEPTH       = 4,
  parameter int FLIT_W      = 64,
  parameter int MAX_PKT_LEN = 4,
  parameter int BUS_DATA_W  = 32,
  parameter int BUS_ADDR_W  = 32,
  parameter int BURST_W     = 7
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_CH*MAX_PKT_LEN*FLIT_W-1:0]   in_link_i,
  input  logic [N_CH*MAX_PKT_LEN-1:0]          in_sel_i,
  input  logic [N_CH-1:0]                      r_pkt_to_msg_i,
  output logic [N_CH-1:0]                      g_pkt_to_msg_o,
  output logic                                 r_bus_arbitration_o,
  output logic [BUS_ADDR_W-1:0]                address_o,
  output logic [BUS_DATA_W-1:0]                data_o,
  output logic [BUS_DATA_W/8-1:0]              sel_o,
  output logic                                 transaction_type_o,
  output logic [BURST_W-1:0]                   burst_lenght_o,
  output logic [((clog2(N_CH) < 1) ? 1 : clog2(N_CH))-1:0] head_ch_o,
  output logic [clog2(DEPTH+1)-1:0]            count_o,
  input  logic                                 next_data_i,
  input  logic                                 retry_i,
  input  logic                                 message_transmitted_i
);

  localparam int CH_W    = (clog2(N_CH) < 1) ? 1 : clog2(N_CH);
  localparam int CNT_W   = clog2(DEPTH + 1);
  localparam int PTR_W   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int PKT_W   = MAX_PKT_LEN * FLIT_W;
  localparam int SEL_W   = BUS_DATA_W / 8;
  localparam int CMD_LSB = FLIT_W - FLIT_TYPE_BITS - CMD_BITS_HEAD_FLIT;

  logic [PKT_W-1:0]       slot_data [DEPTH];
  logic [MAX_PKT_LEN-1:0] slot_sel  [DEPTH];
  logic [CH_W-1:0]        slot_ch   [DEPTH];

  logic [PTR_W-1:0]       head, tail;
  logic [CNT_W-1:0]       count;
  logic [BURST_W-1:0]     beat;
  logic [N_CH-1:0]        gnt_q, gnt_next;
  logic                   grant_en, store, pop, valid;
  logic [CH_W-1:0]        store_ch;
  logic [PKT_W-1:0]       store_link;
  logic [MAX_PKT_LEN-1:0] store_sel;

  assign store = |gnt_q;
  assign valid = (count != '0);
  assign pop   = message_transmitted_i && valid;
  // A grant already in flight will consume a slot on the next edge.
  assign grant_en = (DEPTH - int'(count)) > (store ? 1 : 0);

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (r_pkt_to_msg_i),
    .mask (gnt_q),
    .en   (grant_en),
    .gnt  (gnt_next)
  );

  always_comb begin
    store_ch   = '0;
    store_link = '0;
    store_sel  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt_q[c]) begin
        store_ch   = CH_W'(c);
        store_link = in_link_i[c*PKT_W +: PKT_W];
        store_sel  = in_sel_i[c*MAX_PKT_LEN +: MAX_PKT_LEN];
      end
    end
  end

  logic [PKT_W-1:0] head_data, head_shift;
  logic             is_read, last_beat;
  logic [SEL_W-1:0] sel_c;
  int               nf, burst, rem_bytes;

  always_comb begin
    head_data  = slot_data[head];
    nf         = popcount_sel(64'(slot_sel[head]));
    is_read    = (nf == 1) && (head_data[CMD_LSB +: CMD_BITS_HEAD_FLIT] == CMD_READ);
    burst      = is_read ? 1 : burst_from_flits(nf, FLIT_W, BUS_DATA_W);
    last_beat  = (int'(beat) == burst - 1);
    rem_bytes  = ((nf * FLIT_W) % BUS_DATA_W) / 8;
    sel_c      = '1;
    if (!is_read && last_beat && rem_bytes != 0)
      sel_c = SEL_W'((1 << rem_bytes) - 1);
    head_shift = head_data >> (int'(beat) * BUS_DATA_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      beat  <= '0;
    end else begin
      gnt_q <= gnt_next;
      if (store) tail <= (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;
      if (pop)   head <= (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
      if (store && !pop)      count <= count + 1'b1;
      else if (pop && !store) count <= count - 1'b1;
      if (message_transmitted_i || retry_i)
        beat <= '0;
      else if (next_data_i && valid && (int'(beat) < burst - 1))
        beat <= beat + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && store) begin
      slot_data[tail] <= store_link;
      slot_sel[tail]  <= store_sel;
      slot_ch[tail]   <= store_ch;
    end
  end

  assign g_pkt_to_msg_o      = gnt_q;
  assign count_o             = count;
  assign r_bus_arbitration_o = valid;
  assign address_o           = valid ? head_data[BUS_ADDR_W-1:0] : '0;
  assign data_o              = valid ? head_shift[BUS_DATA_W-1:0] : '0;
  assign sel_o               = valid ? sel_c : '0;
  assign transaction_type_o  = valid && !is_read;
  assign burst_lenght_o      = valid ? BURST_W'(burst) : '0;
  assign head_ch_o           = valid ? slot_ch[head] : '0;

endmodule

// File: tb/tb_msg_queue_mc.sv
// Bench for msg_queue_mc: queue-level reference model checked every cycle,
// plus directed literal expectations.
module tb_msg_queue_mc;
  import msg_queue_pkg::*;

  localparam int N_CH  = 2;
  localparam int DEPTH = 4;
  localparam int FW    = 64;
  localparam int MAXL  = 4;
  localparam int BW    = 32;
  localparam int AW    = 32;
  localparam int BUW   = 7;
  localparam int PKT_W = MAXL * FW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PKT_W-1:0]  link_ch [N_CH];
  logic [MAXL-1:0]   sel_ch  [N_CH];
  logic [N_CH*PKT_W-1:0] in_link;
  logic [N_CH*MAXL-1:0]  in_sel;
  logic [N_CH-1:0]   req = '0;
  logic [N_CH-1:0]   gnt;
  logic              rbus, ttype, next_d = 1'b0, retry = 1'b0, mtx = 1'b0;
  logic [AW-1:0]     addr;
  logic [BW-1:0]     data;
  logic [BW/8-1:0]   sel;
  logic [BUW-1:0]    blen;
  logic [0:0]        hch;
  logic [2:0]        cnt;

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      in_link[c*PKT_W +: PKT_W] = link_ch[c];
      in_sel[c*MAXL +: MAXL]    = sel_ch[c];
    end
  end

  msg_queue_mc dut (
    .clk(clk), .rst(rst), .in_link_i(in_link), .in_sel_i(in_sel),
    .r_pkt_to_msg_i(req), .g_pkt_to_msg_o(gnt), .r_bus_arbitration_o(rbus),
    .address_o(addr), .data_o(data), .sel_o(sel), .transaction_type_o(ttype),
    .burst_lenght_o(blen), .head_ch_o(hch), .count_o(cnt),
    .next_data_i(next_d), .retry_i(retry), .message_transmitted_i(mtx)
  );

  typedef struct { logic [PKT_W-1:0] data; int nf; int ch; } msg_t;
  msg_t q[$];
  int   m_gnt = -1, m_prio = 0, m_ptr = 0;
  int   checks = 0, errors = 0;
  bit   checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_read(input msg_t m);
    logic [1:0] cmd;
    cmd = m.data[61:60];
    return (m.nf == 1) && (cmd == CMD_READ);
  endfunction

  function automatic int m_burst(input msg_t m);
    return m_read(m) ? 1 : (m.nf * FW + BW - 1) / BW;
  endfunction

  // Reference model: message queue, pending grant and beat pointer.
  always @(posedge clk) begin
    int   old_size, ng, np, c;
    msg_t m;
    old_size = q.size();
    if (rst) begin
      q.delete(); m_gnt = -1; m_prio = 0; m_ptr = 0;
    end else begin
      ng = -1; np = m_prio;
      if (DEPTH - old_size > ((m_gnt >= 0) ? 1 : 0))
        for (int i = 0; i < N_CH; i++) begin
          c = (m_prio + i) % N_CH;
          if (ng < 0 && req[c] && c != m_gnt) begin ng = c; np = (c + 1) % N_CH; end
        end
      if (mtx || retry) m_ptr = 0;
      else if (next_d && old_size > 0 && m_ptr < m_burst(q[0]) - 1) m_ptr++;
      if (mtx && old_size > 0) void'(q.pop_front());
      if (m_gnt >= 0) begin
        m.data = link_ch[m_gnt];
        m.nf   = $countones(sel_ch[m_gnt]);
        m.ch   = m_gnt;
        q.push_back(m);
      end
      m_gnt = ng; m_prio = np;
    end
  end

  always @(negedge clk) begin
    msg_t h;
    int   b, rem;
    logic [PKT_W-1:0] sh;
    logic [3:0] es;
    if (checking) begin
      chk("grant", 64'(gnt), (m_gnt >= 0) ? 64'(1 << m_gnt) : 64'd0);
      chk("count", 64'(cnt), 64'(q.size()));
      chk("r_bus", 64'(rbus), 64'(q.size() != 0));
      if (q.size() > 0) begin
        h   = q[0];
        b   = m_burst(h);
        sh  = h.data >> (m_ptr * BW);
        rem = ((h.nf * FW) % BW) / 8;
        es  = (!m_read(h) && m_ptr == b - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
        chk("address", 64'(addr), 64'(h.data[AW-1:0]));
        chk("data", 64'(data), 64'(sh[BW-1:0]));
        chk("sel", 64'(sel), 64'(es));
        chk("type", 64'(ttype), 64'(!m_read(h)));
        chk("burst", 64'(blen), 64'(b));
        chk("head_ch", 64'(hch), 64'(h.ch));
      end else begin
        chk("idle_outs", {addr, data}, 64'd0);
        chk("idle_ctl", 64'({sel, ttype, blen, hch}), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_pkt(input int c, input int nf, input logic [27:0] base, input logic [1:0] cmd);
    logic [FW-1:0] f;
    logic [27:0]   lo, hi;
    link_ch[c] = '0;
    for (int i = 0; i < MAXL; i++) begin
      lo = base + 28'(2 * i);
      hi = base + 28'(2 * i + 1);
      f  = {2'b00, cmd, hi, 4'h0, lo};
      if (i < nf) link_ch[c][i*FW +: FW] = f;
    end
    sel_ch[c] = MAXL'((1 << nf) - 1);
  endtask

  initial begin
    for (int c = 0; c < N_CH; c++) begin link_ch[c] = '0; sel_ch[c] = '0; end
    rst = 1'b1;
    tick(); tick();
    checking = 1'b1;
    chk("rst_grant", 64'(gnt), 64'd0);
    chk("rst_count", 64'(cnt), 64'd0);
    chk("rst_rbus", 64'(rbus), 64'd0);
    rst = 1'b0;

    // 3-flit write on channel 0: burst 6, words in order
    set_pkt(0, 3, 28'h100, 2'b00);
    req = 2'b01; tick();
    chk("t1_grant", 64'(gnt), 64'h1);
    req = 2'b00; tick();
    chk("t1_count", 64'(cnt), 64'd1);
    chk("t1_burst", 64'(blen), 64'd6);
    chk("t1_data0", 64'(data), 64'h100);
    for (int k = 1; k <= 6; k++) begin
      next_d = 1'b1; tick(); next_d = 1'b0;
      chk("t1_sel", 64'(sel), 64'hF);
      chk("t1_data", 64'(data), 64'h100 + 64'((k > 5) ? 5 : k));
    end
    mtx = 1'b1; tick(); mtx = 1'b0;
    chk("t1_pop", 64'(cnt), 64'd0);

    // retry handling on channel 0 write
    set_pkt(0, 3, 28'h200, 2'b00);
    req = 2'b01; tick(); req = 2'b00; tick();
    next_d = 1'b1; tick(); tick(); tick(); next_d = 1'b0;
    chk("t4_beat3", 64'(data), 64'h203);
    retry = 1'b1; tick(); retry = 1'b0;
    chk("t4_retry", 64'(data), 64'h200);
    next_d = 1'b1; tick(); tick();
    chk("t4_beat2", 64'(data), 64'h202);
    retry = 1'b1; tick(); retry = 1'b0; next_d = 1'b0;
    chk("t4_retry_next", 64'(data), 64'h200);
    mtx = 1'b1; tick(); mtx = 1'b0;

    // 1-flit read on channel 1
    set_pkt(1, 1, 28'h300, CMD_READ);
    req = 2'b10; tick();
    chk("t3_grant", 64'(gnt), 64'h2);
    req = 2'b00; tick();
    chk("t3_type", 64'(ttype), 64'd0);
    chk("t3_burst", 64'(blen), 64'd1);
    chk("t3_sel", 64'(sel), 64'hF);
    chk("t3_head_ch", 64'(hch), 64'd1);
    chk("t3_addr", 64'(addr), 64'h300);
    mtx = 1'b1; tick(); mtx = 1'b0;

    // both channels requesting: alternate until full
    set_pkt(0, 1, 28'h400, 2'b00);
    set_pkt(1, 2, 28'h500, 2'b00);
    req = 2'b11;
    tick(); chk("t2_g1", 64'(gnt), 64'h1);
    tick(); chk("t2_g2", 64'(gnt), 64'h2);
    tick(); chk("t2_g3", 64'(gnt), 64'h1);
    tick(); chk("t2_g4", 64'(gnt), 64'h2);
    chk("t2_cnt3", 64'(cnt), 64'd3);
    tick(); chk("t2_full_g", 64'(gnt), 64'h0);
    chk("t2_full", 64'(cnt), 64'd4);
    tick(); chk("t2_hold_g", 64'(gnt), 64'h0);
    mtx = 1'b1; tick(); mtx = 1'b0;
    chk("t2_popcnt", 64'(cnt), 64'd3);
    chk("t2_pop_g", 64'(gnt), 64'h0);
    tick(); chk("t2_regrant", 64'(gnt), 64'h1);
    tick(); chk("t2_one_only", 64'(gnt), 64'h0);
    chk("t2_refull", 64'(cnt), 64'd4);
    req = 2'b00;
    mtx = 1'b1; tick(); tick(); mtx = 1'b0;
    chk("t5_cnt2", 64'(cnt), 64'd2);

    // store coincident with pop at count 2
    set_pkt(1, 4, 28'h600, 2'b00);
    req = 2'b10; tick();
    chk("t5_grant", 64'(gnt), 64'h2);
    req = 2'b00; mtx = 1'b1; tick(); mtx = 1'b0;
    chk("t5_same_cnt", 64'(cnt), 64'd2);
    mtx = 1'b1; tick();
    next_d = 1'b1; tick(); tick(); next_d = 1'b0;
    tick(); tick();
    mtx = 1'b0;
    chk("t5_empty_pop", 64'(cnt), 64'd0);
    chk("t5_empty_rbus", 64'(rbus), 64'd0);
    set_pkt(0, 2, 28'h680, 2'b00);
    req = 2'b01; tick(); req = 2'b00; tick();
    chk("t5_wrap_addr", 64'(addr), 64'h680);
    mtx = 1'b1; tick(); mtx = 1'b0;

    // reset during a grant cycle
    set_pkt(0, 2, 28'h700, 2'b00);
    req = 2'b01; tick();
    chk("t6_grant", 64'(gnt), 64'h1);
    rst = 1'b1; req = 2'b00; tick(); rst = 1'b0;
    chk("t6_g", 64'(gnt), 64'h0);
    chk("t6_cnt", 64'(cnt), 64'd0);
    chk("t6_rbus", 64'(rbus), 64'd0);
    tick(); tick();
    chk("t6_nostore", 64'(cnt), 64'd0);

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_queue_mc.md
Name: msg_queue_mc

Overview:
- Parametrised successor of the PACKET2MESSAGE queue.
- Accepts whole packets from N_CH input flit buffers (one per virtual channel) through round-robin request/grant, and stores them in a DEPTH-entry FIFO.
- Presents the head message to the wb_master_interface as address, data, sel, type and burst length, with retry and beat tracking.
- Adds over the previous generation: multi-channel arbitration, back-to-back grants, an occupancy counter, and exact byte-select on the last beat.

Parameters:
- N_CH, 2, number of input channels (≥1).
- DEPTH, 4, number of message slots (≥2, any value; pointers wrap explicitly).
- FLIT_W, 64, flit width in bits.
- MAX_PKT_LEN, 4, maximum flits per packet.
- BUS_DATA_W, 32, WISHBONE data width; FLIT_W must be a multiple of BUS_DATA_W.
- BUS_ADDR_W, 32, address width; must be ≤ FLIT_W.
- BURST_W, 7, width of burst-length and beat pointer.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_link_i  in  N_CH*MAX_PKT_LEN*FLIT_W  packet data per channel; flit 0 is the head flit
- in_sel_i  in  N_CH*MAX_PKT_LEN  valid flits per channel, contiguous from bit 0
- r_pkt_to_msg_i  in  N_CH  storage request per channel
- g_pkt_to_msg_o  out  N_CH  one-hot registered grant
- r_bus_arbitration_o  out  1  head slot valid
- address_o  out  BUS_ADDR_W  head flit bits [BUS_ADDR_W-1:0]
- data_o  out  BUS_DATA_W  current beat of head message
- sel_o  out  BUS_DATA_W/8  byte enables for current beat
- transaction_type_o  out  1  1 = write, 0 = read
- burst_lenght_o  out  BURST_W  beats for the head message
- head_ch_o  out  clog2(N_CH) (min 1)  channel that supplied the head message
- count_o  out  clog2(DEPTH+1)  occupied slots
- next_data_i  in  1  advance to next beat
- retry_i  in  1  restart head message at beat 0
- message_transmitted_i  in  1  head message complete; pop

Behaviour:
- Reset values: all outputs 0; count_o = 0; head/tail pointers = 0; RR priority pointer = 0; beat pointer = 0. Slot contents are don't-care.
- Grant logic:
  - grant_next picks one requesting channel round-robin, starting at the priority pointer.
  - The channel currently granted is excluded, so a channel is never granted two cycles in a row.
  - A grant is issued only if free slots > (|g_pkt_to_msg_o ? 1 : 0), i.e. a pending store is counted.
  - g_pkt_to_msg_o is registered and lasts one cycle. After a grant to channel c, the priority pointer moves to c+1 mod N_CH.
- Store:
  - On the edge where g_pkt_to_msg_o[c] = 1, in_link_i/in_sel_i slice c and the channel id are written at tail; tail advances with wrap at DEPTH-1.
  - The requester must hold its data valid during the grant cycle.
- Pop:
  - message_transmitted_i with count > 0 frees the head slot and advances head with wrap.
  - message_transmitted_i with count = 0 is ignored.
- count_o: +1 on store, -1 on pop, unchanged when both occur in the same cycle. It never exceeds DEPTH or goes below 0.
- r_bus_arbitration_o = (count_o != 0). It is combinational from registered state.
- Message decode, with nf = number of valid flits of the head message:
  - Read when nf == 1 and the command field of flit 0 equals CMD_READ; write otherwise.
  - Read: burst_lenght_o = 1.
  - Write: burst_lenght_o = ceil(nf*FLIT_W / BUS_DATA_W).
  - If nf == 1 on a write, the payload is flit 0 itself (head_tail write, address in low bits, data above), matching the existing message format.
- Beat pointer:
  - Cleared on message_transmitted_i or retry_i; these have priority over next_data_i.
  - Otherwise +1 on next_data_i, saturating at burst_lenght_o-1.
  - data_o = head data[(ptr+1)*BUS_DATA_W-1 : ptr*BUS_DATA_W].
- sel_o:
  - All ones for reads and for non-last beats.
  - Last write beat: the low ((nf*FLIT_W) mod BUS_DATA_W)/8 bytes set, or all ones if that value is 0.
- Simultaneous store and pop on an empty queue: the store takes effect; the pop is ignored.
- Store into the last free slot while popping is legal.
- Reset during a grant cycle: the store is suppressed and the grant clears.

Decomposition:
- Package msg_queue_pkg holds:
  - flit-type and command field positions (FLIT_TYPE_BITS, CMD_BITS_HEAD_FLIT)
  - HEAD_TAIL_FLIT, CMD_READ
  - function clog2
  - functions popcount_sel and burst_from_flits
- Sub-module rr_arbiter (N_CH requests, mask, one-hot grant, priority update) instantiated once.

Test Plan:
- Single channel, 3-flit write, FLIT_W=64, BUS_DATA_W=32 → grant 1 cycle after request; count_o = 1; burst_lenght_o = 6; 6 next_data_i pulses step data_o through the 32-bit words in order; sel_o = 4'hF on every beat.
- Channels 0 and 1 request continuously, DEPTH=4 → grants alternate 01,10,01,10 on consecutive cycles; 4th grant leaves count_o = 4; no 5th grant while full; a pop allows exactly one new grant.
- 1-flit read with CMD_READ → transaction_type_o = 0, burst_lenght_o = 1, sel_o all ones, head_ch_o = requesting channel.
- Write, beat pointer at 3, retry_i → data_o returns to word 0 next cycle; retry_i and next_data_i together → pointer = 0.
- Queue at count 2, message_transmitted_i coincident with a store → count_o stays 2; head and tail both advance with correct wrap at DEPTH-1; message_transmitted_i when empty → no change.
- rst asserted in a grant cycle → g_pkt_to_msg_o = 0, count_o = 0, r_bus_arbitration_o = 0 next cycle; no slot written.
